// File: rtl/puf_batch_runner.sv
// puf_batch_runner: fetches N challenges from the SIRC input memory, runs each
// through the PUF core (with an optional watchdog), writes the responses MSB
// byte first to the output memory, then posts {timeouts, completions} to
// register 2 and pulses userRunClear.
module puf_batch_runner #(
    parameter int CHAL_BYTES           = 16,
    parameter int RESP_BYTES           = 2,
    parameter int INMEM_ADDRESS_WIDTH  = 17,
    parameter int OUTMEM_ADDRESS_WIDTH = 13
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            userRunValue,
    output logic                            userRunClear,
    output logic                            register32CmdReq,
    input  logic                            register32CmdAck,
    output logic [7:0]                      register32Address,
    output logic                            register32WriteEn,
    output logic [31:0]                     register32WriteData,
    input  logic                            register32ReadDataValid,
    input  logic [31:0]                     register32ReadData,
    output logic                            inputMemoryReadReq,
    input  logic                            inputMemoryReadAck,
    output logic [INMEM_ADDRESS_WIDTH-1:0]  inputMemoryReadAdd,
    input  logic                            inputMemoryReadDataValid,
    input  logic [7:0]                      inputMemoryReadData,
    output logic                            outputMemoryWriteReq,
    input  logic                            outputMemoryWriteAck,
    output logic [OUTMEM_ADDRESS_WIDTH-1:0] outputMemoryWriteAdd,
    output logic [7:0]                      outputMemoryWriteData,
    output logic                            outputMemoryWriteByteMask,
    output logic                            pufTrigger,
    output logic [CHAL_BYTES*8-1:0]         pufChallenge,
    input  logic                            pufDone,
    input  logic [RESP_BYTES*8-1:0]         pufResponse,
    output logic [7:0]                      LED
);

    localparam int KW = (CHAL_BYTES > 1) ? $clog2(CHAL_BYTES) : 1;
    localparam int JW = (RESP_BYTES > 1) ? $clog2(RESP_BYTES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(CHAL_BYTES - 1);
    localparam logic [JW-1:0] J_LAST = JW'(RESP_BYTES - 1);
    localparam logic [INMEM_ADDRESS_WIDTH-1:0]  IN_ONE  = INMEM_ADDRESS_WIDTH'(1);
    localparam logic [OUTMEM_ADDRESS_WIDTH-1:0] OUT_ONE = OUTMEM_ADDRESS_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PARAM    = 3'd1,
        S_FETCH    = 3'd2,
        S_ISSUE    = 3'd3,
        S_WAIT_PUF = 3'd4,
        S_STORE    = 3'd5,
        S_STATUS   = 3'd6,
        S_CLEAR    = 3'd7
    } state_t;

    // Counters stick at their maximum rather than wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    // Byte j of the response, counted from the most significant byte.
    function automatic logic [7:0] resp_byte(input logic [RESP_BYTES*8-1:0] resp,
                                             input logic [JW-1:0] j);
        logic [RESP_BYTES*8-1:0] sh;
        sh = resp >> (8 * (RESP_BYTES - 1 - int'(j)));
        return sh[7:0];
    endfunction

    state_t                          r_state, state_nxt;
    logic                            r_run_clear, run_clear_nxt;
    logic                            r_cmd_req, cmd_req_nxt;
    logic [7:0]                      r_reg_addr, reg_addr_nxt;
    logic                            r_reg_we, reg_we_nxt;
    logic [31:0]                     r_reg_wdata, reg_wdata_nxt;
    logic                            r_rd_wait, rd_wait_nxt;
    logic                            r_pidx, pidx_nxt;
    logic                            r_in_req, in_req_nxt;
    logic [INMEM_ADDRESS_WIDTH-1:0]  r_in_addr, in_addr_nxt;
    logic                            r_in_wait, in_wait_nxt;
    logic [KW-1:0]                   r_k, k_nxt;
    logic                            r_out_req, out_req_nxt;
    logic [OUTMEM_ADDRESS_WIDTH-1:0] r_out_addr, out_addr_nxt;
    logic [7:0]                      r_out_data, out_data_nxt;
    logic [JW-1:0]                   r_j, j_nxt;
    logic                            r_trig, trig_nxt;
    logic [CHAL_BYTES*8-1:0]         r_chal, chal_nxt;
    logic [RESP_BYTES*8-1:0]         r_resp, resp_nxt;
    logic [15:0]                     r_n, n_nxt;
    logic [23:0]                     r_t, t_nxt;
    logic [15:0]                     r_i, i_nxt;
    logic [23:0]                     r_wd, wd_nxt;
    logic [15:0]                     r_done_cnt, done_nxt;
    logic [15:0]                     r_to_cnt, to_nxt;
    logic                            r_to_seen, to_seen_nxt;

    // State and datapath registers; cleared asynchronously while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_run_clear <= 1'b0;
            r_cmd_req   <= 1'b0;
            r_reg_addr  <= 8'd0;
            r_reg_we    <= 1'b0;
            r_reg_wdata <= 32'd0;
            r_rd_wait   <= 1'b0;
            r_pidx      <= 1'b0;
            r_in_req    <= 1'b0;
            r_in_addr   <= '0;
            r_in_wait   <= 1'b0;
            r_k         <= '0;
            r_out_req   <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= 8'd0;
            r_j         <= '0;
            r_trig      <= 1'b0;
            r_chal      <= '0;
            r_resp      <= '0;
            r_n         <= 16'd0;
            r_t         <= 24'd0;
            r_i         <= 16'd0;
            r_wd        <= 24'd0;
            r_done_cnt  <= 16'd0;
            r_to_cnt    <= 16'd0;
            r_to_seen   <= 1'b0;
        end else begin
            r_state     <= state_nxt;
            r_run_clear <= run_clear_nxt;
            r_cmd_req   <= cmd_req_nxt;
            r_reg_addr  <= reg_addr_nxt;
            r_reg_we    <= reg_we_nxt;
            r_reg_wdata <= reg_wdata_nxt;
            r_rd_wait   <= rd_wait_nxt;
            r_pidx      <= pidx_nxt;
            r_in_req    <= in_req_nxt;
            r_in_addr   <= in_addr_nxt;
            r_in_wait   <= in_wait_nxt;
            r_k         <= k_nxt;
            r_out_req   <= out_req_nxt;
            r_out_addr  <= out_addr_nxt;
            r_out_data  <= out_data_nxt;
            r_j         <= j_nxt;
            r_trig      <= trig_nxt;
            r_chal      <= chal_nxt;
            r_resp      <= resp_nxt;
            r_n         <= n_nxt;
            r_t         <= t_nxt;
            r_i         <= i_nxt;
            r_wd        <= wd_nxt;
            r_done_cnt  <= done_nxt;
            r_to_cnt    <= to_nxt;
            r_to_seen   <= to_seen_nxt;
        end
    end

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_nxt     = r_state;
        run_clear_nxt = 1'b0;
        trig_nxt      = 1'b0;
        cmd_req_nxt   = r_cmd_req;
        reg_addr_nxt  = r_reg_addr;
        reg_we_nxt    = r_reg_we;
        reg_wdata_nxt = r_reg_wdata;
        rd_wait_nxt   = r_rd_wait;
        pidx_nxt      = r_pidx;
        in_req_nxt    = r_in_req;
        in_addr_nxt   = r_in_addr;
        in_wait_nxt   = r_in_wait;
        k_nxt         = r_k;
        out_req_nxt   = r_out_req;
        out_addr_nxt  = r_out_addr;
        out_data_nxt  = r_out_data;
        j_nxt         = r_j;
        chal_nxt      = r_chal;
        resp_nxt      = r_resp;
        n_nxt         = r_n;
        t_nxt         = r_t;
        i_nxt         = r_i;
        wd_nxt        = r_wd;
        done_nxt      = r_done_cnt;
        to_nxt        = r_to_cnt;
        to_seen_nxt   = r_to_seen;
        case (r_state)
            S_IDLE: begin
                if (userRunValue) begin
                    state_nxt     = S_PARAM;
                    cmd_req_nxt   = 1'b1;
                    reg_addr_nxt  = 8'd0;
                    reg_we_nxt    = 1'b0;
                    reg_wdata_nxt = 32'd0;
                    pidx_nxt      = 1'b0;
                    rd_wait_nxt   = 1'b0;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_PARAM: begin
                if (r_cmd_req) begin
                    if (register32CmdAck) begin
                        cmd_req_nxt = 1'b0;
                        rd_wait_nxt = 1'b1;
                    end else begin
                        cmd_req_nxt = 1'b1;
                    end
                end else if (r_rd_wait && register32ReadDataValid) begin
                    rd_wait_nxt = 1'b0;
                    if (!r_pidx) begin
                        n_nxt        = register32ReadData[15:0];
                        pidx_nxt     = 1'b1;
                        cmd_req_nxt  = 1'b1;
                        reg_addr_nxt = 8'd1;
                    end else begin
                        t_nxt        = register32ReadData[23:0];
                        done_nxt     = 16'd0;
                        to_nxt       = 16'd0;
                        i_nxt        = 16'd0;
                        in_addr_nxt  = '0;
                        out_addr_nxt = '0;
                        if (r_n == 16'd0) begin
                            state_nxt     = S_STATUS;
                            cmd_req_nxt   = 1'b1;
                            reg_addr_nxt  = 8'd2;
                            reg_we_nxt    = 1'b1;
                            reg_wdata_nxt = 32'd0;
                        end else begin
                            state_nxt   = S_FETCH;
                            in_req_nxt  = 1'b1;
                            in_wait_nxt = 1'b0;
                            k_nxt       = '0;
                        end
                    end
                end else begin
                    rd_wait_nxt = r_rd_wait;
                end
            end
            S_FETCH: begin
                if (r_in_req) begin
                    if (inputMemoryReadAck) begin
                        in_req_nxt  = 1'b0;
                        in_wait_nxt = 1'b1;
                    end else begin
                        in_req_nxt = 1'b1;
                    end
                end else if (r_in_wait && inputMemoryReadDataValid) begin
                    in_wait_nxt                 = 1'b0;
                    in_addr_nxt                 = r_in_addr + IN_ONE;
                    chal_nxt[int'(r_k)*8 +: 8]  = inputMemoryReadData;
                    if (r_k == K_LAST) begin
                        state_nxt = S_ISSUE;
                        trig_nxt  = 1'b1;
                    end else begin
                        k_nxt      = r_k + KW'(1);
                        in_req_nxt = 1'b1;
                    end
                end else begin
                    in_wait_nxt = r_in_wait;
                end
            end
            S_ISSUE: begin
                // The watchdog reads 1 in the first cycle after the trigger.
                state_nxt = S_WAIT_PUF;
                wd_nxt    = 24'd1;
            end
            S_WAIT_PUF: begin
                if (pufDone) begin
                    resp_nxt    = pufResponse;
                    done_nxt    = sat_inc(r_done_cnt);
                    state_nxt   = S_STORE;
                    out_req_nxt = 1'b0;
                    j_nxt       = '0;
                end else if ((r_t != 24'd0) && (r_wd == r_t)) begin
                    resp_nxt    = '1;
                    to_nxt      = sat_inc(r_to_cnt);
                    to_seen_nxt = 1'b1;
                    state_nxt   = S_STORE;
                    out_req_nxt = 1'b0;
                    j_nxt       = '0;
                end else begin
                    wd_nxt = r_wd + 24'd1;
                end
            end
            S_STORE: begin
                if (r_out_req) begin
                    if (outputMemoryWriteAck) begin
                        out_req_nxt  = 1'b0;
                        out_addr_nxt = r_out_addr + OUT_ONE;
                        if (r_j == J_LAST) begin
                            i_nxt = r_i + 16'd1;
                            if ((r_i + 16'd1) == r_n) begin
                                state_nxt     = S_STATUS;
                                cmd_req_nxt   = 1'b1;
                                reg_addr_nxt  = 8'd2;
                                reg_we_nxt    = 1'b1;
                                reg_wdata_nxt = {r_to_cnt, r_done_cnt};
                            end else begin
                                state_nxt   = S_FETCH;
                                in_req_nxt  = 1'b1;
                                in_wait_nxt = 1'b0;
                                k_nxt       = '0;
                            end
                        end else begin
                            j_nxt = r_j + JW'(1);
                        end
                    end else begin
                        out_req_nxt = 1'b1;
                    end
                end else begin
                    out_req_nxt  = 1'b1;
                    out_data_nxt = resp_byte(r_resp, r_j);
                end
            end
            S_STATUS: begin
                if (register32CmdAck) begin
                    cmd_req_nxt   = 1'b0;
                    state_nxt     = S_CLEAR;
                    run_clear_nxt = 1'b1;
                end else begin
                    cmd_req_nxt = 1'b1;
                end
            end
            S_CLEAR: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign userRunClear              = r_run_clear;
    assign register32CmdReq          = r_cmd_req;
    assign register32Address         = r_reg_addr;
    assign register32WriteEn         = r_reg_we;
    assign register32WriteData       = r_reg_wdata;
    assign inputMemoryReadReq        = r_in_req;
    assign inputMemoryReadAdd        = r_in_addr;
    assign outputMemoryWriteReq      = r_out_req;
    assign outputMemoryWriteAdd      = r_out_addr;
    assign outputMemoryWriteData     = r_out_data;
    assign outputMemoryWriteByteMask = 1'b1;
    assign pufTrigger                = r_trig;
    assign pufChallenge              = r_chal;
    assign LED                       = {r_to_seen, 4'b0000, r_state};

endmodule

// File: tb/tb_puf_batch_runner.sv
// Testbench for puf_batch_runner: behavioural register file, memories and PUF
// core; expected traffic is queued per run and checked by a monitor process.
`timescale 1ns/1ps
module tb_puf_batch_runner;
    localparam int CB  = 16;
    localparam int RB  = 2;
    localparam int IAW = 17;
    localparam int OAW = 13;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             userRunValue = 1'b0;
    logic             userRunClear;
    logic             register32CmdReq;
    logic             register32CmdAck;
    logic [7:0]       register32Address;
    logic             register32WriteEn;
    logic [31:0]      register32WriteData;
    logic             register32ReadDataValid;
    logic [31:0]      register32ReadData;
    logic             inputMemoryReadReq;
    logic             inputMemoryReadAck;
    logic [IAW-1:0]   inputMemoryReadAdd;
    logic             inputMemoryReadDataValid;
    logic [7:0]       inputMemoryReadData;
    logic             outputMemoryWriteReq;
    logic             outputMemoryWriteAck;
    logic [OAW-1:0]   outputMemoryWriteAdd;
    logic [7:0]       outputMemoryWriteData;
    logic             outputMemoryWriteByteMask;
    logic             pufTrigger;
    logic [CB*8-1:0]  pufChallenge;
    logic             pufDone;
    logic [RB*8-1:0]  pufResponse;
    logic [7:0]       LED;

    puf_batch_runner #(.CHAL_BYTES(CB), .RESP_BYTES(RB),
                       .INMEM_ADDRESS_WIDTH(IAW), .OUTMEM_ADDRESS_WIDTH(OAW)) dut (
        .clk(clk), .reset(reset), .userRunValue(userRunValue), .userRunClear(userRunClear),
        .register32CmdReq(register32CmdReq), .register32CmdAck(register32CmdAck),
        .register32Address(register32Address), .register32WriteEn(register32WriteEn),
        .register32WriteData(register32WriteData), .register32ReadDataValid(register32ReadDataValid),
        .register32ReadData(register32ReadData), .inputMemoryReadReq(inputMemoryReadReq),
        .inputMemoryReadAck(inputMemoryReadAck), .inputMemoryReadAdd(inputMemoryReadAdd),
        .inputMemoryReadDataValid(inputMemoryReadDataValid), .inputMemoryReadData(inputMemoryReadData),
        .outputMemoryWriteReq(outputMemoryWriteReq), .outputMemoryWriteAck(outputMemoryWriteAck),
        .outputMemoryWriteAdd(outputMemoryWriteAdd), .outputMemoryWriteData(outputMemoryWriteData),
        .outputMemoryWriteByteMask(outputMemoryWriteByteMask), .pufTrigger(pufTrigger),
        .pufChallenge(pufChallenge), .pufDone(pufDone), .pufResponse(pufResponse), .LED(LED)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_err = 0;
    logic [7:0]   in_mem [0:1023];
    logic [31:0]  reg0_val = 32'd0;
    logic [31:0]  reg1_val = 32'd0;
    int           stall_max = 0;
    int           lat_tab [0:7];
    logic [15:0]  resp_tab [0:7];
    int           puf_idx = 0;
    bit           sb_on = 1'b1;
    int           clear_cnt = 0;
    int           out_wr_cnt = 0;
    int           in_rd_cnt = 0;
    logic [31:0]  exp_out_q [$];
    logic [63:0]  exp_reg_q [$];
    logic [127:0] exp_chal_q [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs_idle(input string name);
        logic any_set;
        any_set = |{userRunClear, register32CmdReq, register32Address, register32WriteEn,
                    register32WriteData, inputMemoryReadReq, inputMemoryReadAdd,
                    outputMemoryWriteReq, outputMemoryWriteAdd, outputMemoryWriteData,
                    pufTrigger, pufChallenge, LED};
        check({name, "_outputs_zero"}, any_set, 1'b0);
        check({name, "_bytemask"}, outputMemoryWriteByteMask, 1'b1);
    endtask

    // Register file: reg0/reg1 are read back, writes are observed by the monitor.
    initial begin : reg_resp
        logic [7:0] a;
        logic       w;
        register32CmdAck = 1'b0; register32ReadDataValid = 1'b0; register32ReadData = 32'd0;
        forever begin
            @(negedge clk);
            if (register32CmdReq) begin
                repeat ($urandom_range(stall_max, 0)) @(negedge clk);
                a = register32Address; w = register32WriteEn;
                register32CmdAck = 1'b1; @(negedge clk); register32CmdAck = 1'b0;
                if (!w) begin
                    repeat ($urandom_range(stall_max, 0)) @(negedge clk);
                    register32ReadData = (a == 8'd0) ? reg0_val : (a == 8'd1) ? reg1_val : 32'hDEADBEEF;
                    register32ReadDataValid = 1'b1; @(negedge clk); register32ReadDataValid = 1'b0;
                    register32ReadData = $urandom;
                end
            end
        end
    end

    // Input memory with random accept and return delays.
    initial begin : in_resp
        logic [IAW-1:0] a;
        inputMemoryReadAck = 1'b0; inputMemoryReadDataValid = 1'b0; inputMemoryReadData = 8'd0;
        forever begin
            @(negedge clk);
            if (inputMemoryReadReq) begin
                repeat ($urandom_range(stall_max, 0)) @(negedge clk);
                a = inputMemoryReadAdd;
                inputMemoryReadAck = 1'b1; @(negedge clk); inputMemoryReadAck = 1'b0;
                repeat ($urandom_range(stall_max, 0)) @(negedge clk);
                inputMemoryReadData = in_mem[a[9:0]];
                inputMemoryReadDataValid = 1'b1; @(negedge clk); inputMemoryReadDataValid = 1'b0;
                inputMemoryReadData = $urandom;
            end
        end
    end

    // Output memory: accepts writes after a random delay.
    initial begin : out_resp
        outputMemoryWriteAck = 1'b0;
        forever begin
            @(negedge clk);
            if (outputMemoryWriteReq) begin
                repeat ($urandom_range(stall_max, 0)) @(negedge clk);
                outputMemoryWriteAck = 1'b1; @(negedge clk); outputMemoryWriteAck = 1'b0;
            end
        end
    end

    // PUF core: answers challenge i lat_tab[i] cycles after its trigger (0 = never).
    initial begin : puf_model
        int idx;
        pufDone = 1'b0; pufResponse = 16'h0000;
        forever begin
            @(negedge clk);
            pufResponse = $urandom;
            if (pufTrigger) begin
                idx = puf_idx; puf_idx++;
                if (lat_tab[idx] != 0) begin
                    repeat (lat_tab[idx]) @(negedge clk);
                    pufResponse = resp_tab[idx]; pufDone = 1'b1;
                    @(negedge clk); pufDone = 1'b0; pufResponse = $urandom;
                end
            end
        end
    end

    // Monitor: samples just before each rising edge and checks against the queues.
    initial begin : monitor
        logic [31:0]  eo;
        logic [63:0]  er;
        logic [127:0] ec;
        forever begin
            @(negedge clk); #3;
            if (inputMemoryReadReq && inputMemoryReadAck) in_rd_cnt++;
            if (userRunClear) clear_cnt++;
            if (outputMemoryWriteReq && outputMemoryWriteAck) begin
                out_wr_cnt++;
                if (sb_on) begin
                    eo = (exp_out_q.size() != 0) ? exp_out_q.pop_front() : 'x;
                    check("out_write", {11'd0, outputMemoryWriteAdd, outputMemoryWriteData}, eo);
                end
            end
            if (register32CmdReq && register32CmdAck && register32WriteEn && sb_on) begin
                er = (exp_reg_q.size() != 0) ? exp_reg_q.pop_front() : 'x;
                check("reg_write", {24'd0, register32Address, register32WriteData}, er);
            end
            if (pufTrigger && sb_on) begin
                ec = (exp_chal_q.size() != 0) ? exp_chal_q.pop_front() : 'x;
                check("puf_challenge", pufChallenge, ec);
            end
        end
    end

    // One batch: queue the expected traffic, start the run, wait for userRunClear.
    task automatic run_batch(input int n, input int t, input string tag);
        int           to_c = 0;
        int           dn_c = 0;
        int           cyc = 0;
        int           clr0;
        logic [127:0] ch;
        logic [15:0]  r;
        logic [7:0]   b;
        logic [31:0]  junk;
        junk = $urandom;
        reg0_val = {junk[31:16], n[15:0]};
        reg1_val = {junk[7:0], t[23:0]};
        puf_idx = 0;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < CB; k++) ch[8*k +: 8] = in_mem[i*CB + k];
            exp_chal_q.push_back(ch);
            if (lat_tab[i] != 0 && (t == 0 || lat_tab[i] <= t)) begin
                r = resp_tab[i]; dn_c++;
            end else begin
                r = 16'hFFFF; to_c++;
            end
            for (int j = 0; j < RB; j++) begin
                b = 8'(r >> (8 * (RB - 1 - j)));
                exp_out_q.push_back(32'(((i * RB + j) << 8) | int'(b)));
            end
        end
        exp_reg_q.push_back({24'd0, 8'd2, to_c[15:0], dn_c[15:0]});
        clr0 = clear_cnt;
        userRunValue = 1'b1;
        while (!userRunClear && cyc < 20000) begin
            @(negedge clk); cyc++;
        end
        userRunValue = 1'b0;
        if (cyc >= 20000) check({tag, "_run_timeout"}, cyc, 0);
        repeat (6) @(negedge clk);
        check({tag, "_clear_pulses"}, clear_cnt - clr0, 1);
        check({tag, "_out_pending"}, exp_out_q.size(), 0);
        check({tag, "_reg_pending"}, exp_reg_q.size(), 0);
        check({tag, "_chal_pending"}, exp_chal_q.size(), 0);
        exp_out_q.delete(); exp_reg_q.delete(); exp_chal_q.delete();
    endtask

    initial begin : main
        int base;
        int cyc;
        for (int a = 0; a < 1024; a++) in_mem[a] = $urandom;
        for (int i = 0; i < 8; i++) begin lat_tab[i] = 5; resp_tab[i] = $urandom; end
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_idle("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single challenge, known bytes, 10-cycle PUF.
        for (int k = 0; k < CB; k++) in_mem[k] = 8'(k);
        lat_tab[0] = 10; resp_tab[0] = 16'hA55A; stall_max = 0;
        run_batch(1, 0, "t1");
        check("t1_chal_hold", pufChallenge, 128'h0F0E0D0C0B0A09080706050403020100);
        check("t1_led", LED, 8'h00);

        // Three challenges, no watchdog, stalls of 0..5 cycles.
        stall_max = 5;
        for (int i = 0; i < 3; i++) begin lat_tab[i] = $urandom_range(20, 1); resp_tab[i] = $urandom; end
        run_batch(3, 0, "t2");

        // Second challenge never answered, watchdog 50.
        stall_max = 2;
        lat_tab[0] = 7; lat_tab[1] = 0;
        run_batch(2, 50, "t3");
        check("t3_led", LED, 8'h80);

        // pufDone exactly when the watchdog reaches T, then one cycle late.
        stall_max = 0;
        lat_tab[0] = 12; resp_tab[0] = 16'h1234;
        run_batch(1, 12, "t4a");
        lat_tab[0] = 13;
        run_batch(1, 12, "t4b");

        // Empty batch: no memory traffic.
        base = out_wr_cnt; cyc = in_rd_cnt;
        run_batch(0, 0, "t5");
        check("t5_no_writes", out_wr_cnt - base, 0);
        check("t5_no_reads", in_rd_cnt - cyc, 0);

        // Reset while storing the second response of a 4-challenge batch.
        sb_on = 1'b0; stall_max = 0;
        for (int i = 0; i < 4; i++) lat_tab[i] = 4;
        reg0_val = 32'd4; reg1_val = 32'd0; puf_idx = 0;
        base = out_wr_cnt; cyc = 0;
        userRunValue = 1'b1;
        while (!(LED[2:0] == 3'd5 && out_wr_cnt >= base + 2) && cyc < 5000) begin
            @(negedge clk); cyc++;
        end
        if (cyc >= 5000) check("t6_reach_store", cyc, 0);
        reset = 1'b0;
        #1;
        check_outputs_idle("t6_async");
        userRunValue = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_idle("t6_held");
        reset = 1'b1;
        repeat (8) @(negedge clk);
        exp_out_q.delete(); exp_reg_q.delete(); exp_chal_q.delete();
        sb_on = 1'b1;
        lat_tab[0] = 6; resp_tab[0] = $urandom;
        run_batch(1, 0, "t6b");

        // Random batch with a mix of answered, late and silent challenges.
        stall_max = 3;
        for (int i = 0; i < 6; i++) begin lat_tab[i] = $urandom_range(40, 0); resp_tab[i] = $urandom; end
        run_batch(6, 30, "t7");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
